// File: rtl/qam16_outbuf_ctrl.sv
// ---------------------------------------------------------------------------
// qam16_outbuf_ctrl
// Burst sequencer for the QAM16 demapper output buffer (nibble-in / dibit-out).
// Admits exactly one burst of ACTIVE_SUBCARR*SYMBOL_NUM nibbles into the
// buffer and waits for the buffer's full flag. It then frames the 2-bit drain
// with dout_valid/dout_sof/dout_eof and pulses tx_done to rearm the buffer.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   demap_valid  demapper nibble valid
//   demap_sof    first nibble of a burst (qualified by demap_valid)
//   buff_full    buffer full flag (registered inside the buffer)
//   clr_status   synchronous clear of ovf_err/sof_err/drop_cnt (and wdog_err)
//   din_valid    buffer write enable (combinational)
//   tx_done      one-cycle buffer rearm pulse (registered)
//   dout_valid   buffer dout carries a valid dibit this cycle
//   dout_sof     first dibit of a burst
//   dout_eof     last dibit of a burst
//   busy         sequencer not idle
//   ovf_err      sticky: nibble dropped while not accepting
//   sof_err      sticky: sof mid-fill, or buff_full high in IDLE/FILL
//   drop_cnt     dropped-nibble count, saturating at 255
//   wdog_err     sticky fill-stall timeout (only with the watchdog build)
//
// Optional feature: define QAM16_OUTBUF_CTRL_WDOG_EN to add a fill-stall
// watchdog (WDOG_CYCLES idle cycles in FILL abort the burst) and wdog_err.
// ---------------------------------------------------------------------------
module qam16_outbuf_ctrl #(
    parameter int ACTIVE_SUBCARR = 28,
    parameter int SYMBOL_NUM     = 8,
    parameter int WDOG_CYCLES    = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       demap_valid,
    input  logic       demap_sof,
    input  logic       buff_full,
    input  logic       clr_status,
    output logic       din_valid,
    output logic       tx_done,
    output logic       dout_valid,
    output logic       dout_sof,
    output logic       dout_eof,
    output logic       busy,
    output logic       ovf_err,
    output logic       sof_err,
    output logic [7:0] drop_cnt
`ifdef QAM16_OUTBUF_CTRL_WDOG_EN
    ,
    output logic       wdog_err
`endif
);

    localparam int         N_NIB   = ACTIVE_SUBCARR * SYMBOL_NUM;
    localparam int         N_DIB   = 2 * N_NIB;
    localparam logic [8:0] N_NIB_C = 9'(N_NIB);
    localparam logic [9:0] N_DIB_C = 10'(N_DIB);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WAIT_FULL,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [8:0] fill_cnt_q, fill_cnt_d;
    logic [9:0] drain_cnt_q, drain_cnt_d;
    logic       tx_done_q, tx_done_d;
    logic       dout_valid_q, dout_valid_d;
    logic       dout_sof_q, dout_sof_d;
    logic       dout_eof_q, dout_eof_d;
    logic       ovf_q, ovf_d;
    logic       sof_err_q, sof_err_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic       accept;
    logic       drop;

`ifdef QAM16_OUTBUF_CTRL_WDOG_EN
    localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);
    logic [15:0] stall_q, stall_d;
    logic        wdog_err_q, wdog_err_d;
`else
    // Without the watchdog the timeout length has no effect.
    if (WDOG_CYCLES > 0) begin : g_wdog_unused
    end
`endif

    // A burst may only start on a sof nibble; anything offered outside
    // IDLE-with-sof or FILL never reaches the buffer and counts as a drop.
    assign accept    = ((state_q == S_IDLE) && demap_sof) || (state_q == S_FILL);
    assign din_valid = demap_valid & accept;
    assign drop      = demap_valid & ~accept;

    always_comb begin
        state_d      = state_q;
        fill_cnt_d   = fill_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        tx_done_d    = 1'b0;
        dout_valid_d = 1'b0;
        dout_sof_d   = 1'b0;
        dout_eof_d   = 1'b0;
`ifdef QAM16_OUTBUF_CTRL_WDOG_EN
        stall_d      = 16'd0;
        wdog_err_d   = clr_status ? 1'b0 : wdog_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (demap_valid && demap_sof) begin
                    fill_cnt_d = 9'd1;
                    state_d    = S_FILL;
                end
            end
            S_FILL: begin
                if (demap_valid) begin
                    fill_cnt_d = fill_cnt_q + 9'd1;
                    if (fill_cnt_q + 9'd1 == N_NIB_C) begin
                        state_d = S_WAIT_FULL;
                    end
                end
`ifdef QAM16_OUTBUF_CTRL_WDOG_EN
                else if (stall_q == WDOG_LAST) begin
                    state_d    = S_DONE;
                    tx_done_d  = 1'b1;
                    wdog_err_d = 1'b1;
                end else begin
                    stall_d = stall_q + 16'd1;
                end
`endif
            end
            S_WAIT_FULL: begin
                // Buffer presents its first dibit after this edge, so the
                // framing flags are registered in step with it.
                if (buff_full) begin
                    state_d      = S_DRAIN;
                    dout_valid_d = 1'b1;
                    dout_sof_d   = 1'b1;
                    dout_eof_d   = (N_DIB_C == 10'd1);
                    drain_cnt_d  = 10'd1;
                end
            end
            S_DRAIN: begin
                // drain_cnt_q is the index of the dibit currently on dout.
                if (drain_cnt_q == N_DIB_C) begin
                    state_d   = S_DONE;
                    tx_done_d = 1'b1;
                end else begin
                    dout_valid_d = 1'b1;
                    drain_cnt_d  = drain_cnt_q + 10'd1;
                    dout_eof_d   = (drain_cnt_q + 10'd1 == N_DIB_C);
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                fill_cnt_d  = 9'd0;
                drain_cnt_d = 10'd0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sticky status: clear first, then let a same-cycle event win.
    always_comb begin
        ovf_d      = clr_status ? 1'b0 : ovf_q;
        sof_err_d  = clr_status ? 1'b0 : sof_err_q;
        drop_cnt_d = clr_status ? 8'd0 : drop_cnt_q;
        if (drop) begin
            ovf_d = 1'b1;
            if (drop_cnt_d != 8'hFF) begin
                drop_cnt_d = drop_cnt_d + 8'd1;
            end
        end
        if ((state_q == S_FILL && demap_valid && demap_sof) ||
            ((state_q == S_IDLE || state_q == S_FILL) && buff_full)) begin
            sof_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            fill_cnt_q   <= 9'd0;
            drain_cnt_q  <= 10'd0;
            tx_done_q    <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_sof_q   <= 1'b0;
            dout_eof_q   <= 1'b0;
            ovf_q        <= 1'b0;
            sof_err_q    <= 1'b0;
            drop_cnt_q   <= 8'd0;
`ifdef QAM16_OUTBUF_CTRL_WDOG_EN
            stall_q      <= 16'd0;
            wdog_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            fill_cnt_q   <= fill_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            tx_done_q    <= tx_done_d;
            dout_valid_q <= dout_valid_d;
            dout_sof_q   <= dout_sof_d;
            dout_eof_q   <= dout_eof_d;
            ovf_q        <= ovf_d;
            sof_err_q    <= sof_err_d;
            drop_cnt_q   <= drop_cnt_d;
`ifdef QAM16_OUTBUF_CTRL_WDOG_EN
            stall_q      <= stall_d;
            wdog_err_q   <= wdog_err_d;
`endif
        end
    end

    assign tx_done    = tx_done_q;
    assign dout_valid = dout_valid_q;
    assign dout_sof   = dout_sof_q;
    assign dout_eof   = dout_eof_q;
    assign busy       = (state_q != S_IDLE);
    assign ovf_err    = ovf_q;
    assign sof_err    = sof_err_q;
    assign drop_cnt   = drop_cnt_q;
`ifdef QAM16_OUTBUF_CTRL_WDOG_EN
    assign wdog_err   = wdog_err_q;
`endif

endmodule

// File: tb/tb_qam16_outbuf_ctrl.sv
// ---------------------------------------------------------------------------
// tb_qam16_outbuf_ctrl
// Directed sequence of randomized bursts for qam16_outbuf_ctrl. A negedge
// monitor accumulates per-signal totals and event cycles; each burst is
// judged by the deltas against burst-level expectations (224 nibbles in,
// 448 contiguous dibits out, sof/eof at the ends, one tx_done after eof).
// Status flags follow a small drop/sof-error scoreboard.
// ---------------------------------------------------------------------------
module tb_qam16_outbuf_ctrl;

    localparam int N_NIB = 28 * 8;
    localparam int N_DIB = 2 * N_NIB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       demap_valid = 1'b0;
    logic       demap_sof = 1'b0;
    logic       buff_full = 1'b0;
    logic       clr_status = 1'b0;
    logic       din_valid, tx_done, dout_valid, dout_sof, dout_eof, busy;
    logic       ovf_err, sof_err;
    logic [7:0] drop_cnt;
`ifdef QAM16_OUTBUF_CTRL_WDOG_EN
    logic       wdog_err;
`endif

    qam16_outbuf_ctrl #(
        .ACTIVE_SUBCARR(28),
        .SYMBOL_NUM    (8),
        .WDOG_CYCLES   (1024)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .demap_valid(demap_valid),
        .demap_sof  (demap_sof),
        .buff_full  (buff_full),
        .clr_status (clr_status),
        .din_valid  (din_valid),
        .tx_done    (tx_done),
        .dout_valid (dout_valid),
        .dout_sof   (dout_sof),
        .dout_eof   (dout_eof),
        .busy       (busy),
        .ovf_err    (ovf_err),
        .sof_err    (sof_err),
        .drop_cnt   (drop_cnt)
`ifdef QAM16_OUTBUF_CTRL_WDOG_EN
        ,
        .wdog_err   (wdog_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Monitor: totals and event cycles sampled mid-cycle.
    int cyc = 0, din_tot = 0, dv_tot = 0, sof_tot = 0, eof_tot = 0, tx_tot = 0;
    int sof_cyc = 0, eof_cyc = 0, tx_cyc = 0, run = 0, last_run = 0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (din_valid === 1'b1) din_tot <= din_tot + 1;
        if (dout_valid === 1'b1) begin
            dv_tot <= dv_tot + 1;
            run    <= run + 1;
        end else begin
            if (run != 0) last_run <= run;
            run <= 0;
        end
        if (dout_sof === 1'b1) begin sof_tot <= sof_tot + 1; sof_cyc <= cyc; end
        if (dout_eof === 1'b1) begin eof_tot <= eof_tot + 1; eof_cyc <= cyc; end
        if (tx_done === 1'b1)  begin tx_tot  <= tx_tot + 1;  tx_cyc  <= cyc; end
    end

    // Status scoreboard.
    int exp_drop = 0;
    bit exp_ovf = 1'b0;
    bit exp_sof = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic note_drop();
        exp_ovf = 1'b1;
        if (exp_drop < 255) exp_drop++;
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_ovf_err"}, {31'd0, ovf_err}, {31'd0, exp_ovf});
        chk({tag, "_sof_err"}, {31'd0, sof_err}, {31'd0, exp_sof});
        chk({tag, "_drop_cnt"}, {24'd0, drop_cnt}, exp_drop);
    endtask

    task automatic clear_status(input string tag);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        exp_drop = 0;
        exp_ovf  = 1'b0;
        exp_sof  = 1'b0;
        check_flags(tag);
    endtask

    // One burst: pct = percent chance of a valid nibble per fill cycle,
    // sof_at = index of a stray mid-fill sof (-1 none), drops = nibbles
    // offered during drain, abort_at = dibit index to hit reset at (0 none).
    task automatic run_burst(input string tag, input int pct, input int sof_at,
                             input int drops, input int abort_at);
        int b_din, b_dv, b_sof, b_eof, b_tx;
        int sent, guard, left;
        b_din = din_tot; b_dv = dv_tot; b_sof = sof_tot; b_eof = eof_tot; b_tx = tx_tot;
        sent = 0;
        while (sent < N_NIB) begin
            if (sent == 0 || $urandom_range(0, 99) < pct) begin
                demap_valid = 1'b1;
                demap_sof   = (sent == 0) || (sent == sof_at);
                sent++;
            end else begin
                demap_valid = 1'b0;
                demap_sof   = ($urandom_range(0, 3) == 0);
            end
            tick();
        end
        demap_valid = 1'b0;
        demap_sof   = 1'b0;
        if (sof_at > 0 && sof_at < N_NIB) exp_sof = 1'b1;
        repeat ($urandom_range(0, 4)) tick();
        chk({tag, "_wait_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_wait_dv"}, {31'd0, dout_valid}, 32'd0);
        buff_full = 1'b1;
        tick();
        chk({tag, "_first_sof"}, {31'd0, dout_sof}, 32'd1);
        chk({tag, "_first_dv"}, {31'd0, dout_valid}, 32'd1);
        guard = 0;
        left  = drops;
        while (tx_done !== 1'b1 && guard < 1000) begin
            if (abort_at != 0 && guard + 1 == abort_at) begin
                chk({tag, "_pre_rst_dv"}, {31'd0, dout_valid}, 32'd1);
                #2 rst_n = 1'b0;
                #1;
                chk({tag, "_rst_dv"}, {31'd0, dout_valid}, 32'd0);
                chk({tag, "_rst_sof"}, {31'd0, dout_sof}, 32'd0);
                chk({tag, "_rst_eof"}, {31'd0, dout_eof}, 32'd0);
                chk({tag, "_rst_tx"}, {31'd0, tx_done}, 32'd0);
                chk({tag, "_rst_busy"}, {31'd0, busy}, 32'd0);
                exp_drop = 0; exp_ovf = 1'b0; exp_sof = 1'b0;
                check_flags({tag, "_rst"});
                buff_full = 1'b0;
                tick();
                rst_n = 1'b1;
                tick();
                chk({tag, "_rst_idle_busy"}, {31'd0, busy}, 32'd0);
                return;
            end
            if (left > 0 && ($urandom_range(0, 19) == 0 || guard > 300)) begin
                demap_valid = 1'b1;
                demap_sof   = 1'($urandom_range(0, 1));
                left--;
                note_drop();
                #1;
                chk({tag, "_drain_din"}, {31'd0, din_valid}, 32'd0);
            end else begin
                demap_valid = 1'b0;
                demap_sof   = 1'b0;
            end
            tick();
            guard++;
        end
        demap_valid = 1'b0;
        demap_sof   = 1'b0;
        chk({tag, "_tx_seen"}, {31'd0, tx_done}, 32'd1);
        buff_full = 1'b0;
        chk({tag, "_done_dv"}, {31'd0, dout_valid}, 32'd0);
        chk({tag, "_done_busy"}, {31'd0, busy}, 32'd1);
        tick();
        chk({tag, "_tx_single"}, {31'd0, tx_done}, 32'd0);
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        tick();
        tick();
        chk({tag, "_din_count"}, din_tot - b_din, N_NIB);
        chk({tag, "_dv_count"}, dv_tot - b_dv, N_DIB);
        chk({tag, "_dv_run"}, last_run, N_DIB);
        chk({tag, "_sof_count"}, sof_tot - b_sof, 1);
        chk({tag, "_eof_count"}, eof_tot - b_eof, 1);
        chk({tag, "_tx_count"}, tx_tot - b_tx, 1);
        chk({tag, "_eof_pos"}, eof_cyc - sof_cyc, N_DIB - 1);
        chk({tag, "_tx_pos"}, tx_cyc - eof_cyc, 1);
        check_flags(tag);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_din_valid", {31'd0, din_valid}, 32'd0);
        chk("rst_tx_done", {31'd0, tx_done}, 32'd0);
        chk("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        check_flags("rst");
        rst_n = 1'b1;
        tick();

        // Back-to-back burst
        run_burst("b2b", 100, -1, 0, 0);

        // 50% valid fill with 3 drops during drain, then clear
        run_burst("half", 50, -1, 3, 0);
        clear_status("half_clr");

        // Stray sof at nibble 10
        run_burst("sof10", 70, 10, 0, 0);
        clear_status("sof10_clr");

        // Non-sof nibbles in IDLE are dropped; clear coincident with a drop
        for (int i = 0; i < 2; i++) begin
            demap_valid = 1'b1;
            demap_sof   = 1'b0;
            #1;
            chk("idle_drop_din", {31'd0, din_valid}, 32'd0);
            note_drop();
            tick();
        end
        check_flags("idle_drop");
        clr_status = 1'b1;
        exp_drop = 0; exp_ovf = 1'b0; exp_sof = 1'b0;
        note_drop();
        tick();
        clr_status  = 1'b0;
        demap_valid = 1'b0;
        check_flags("clr_vs_drop");
        chk("clr_vs_drop_busy", {31'd0, busy}, 32'd0);
        clear_status("clr2");

        // buff_full while idle is a framing error, no state change
        buff_full = 1'b1;
        tick();
        buff_full = 1'b0;
        exp_sof = 1'b1;
        check_flags("idle_full");
        chk("idle_full_busy", {31'd0, busy}, 32'd0);
        clear_status("idle_full_clr");

        // drop_cnt saturates at 255
        demap_valid = 1'b1;
        demap_sof   = 1'b0;
        for (int i = 0; i < 260; i++) begin
            note_drop();
            tick();
        end
        demap_valid = 1'b0;
        check_flags("sat");
        clear_status("sat_clr");

        // Reset at dibit 100, then a normal burst with drain drops
        run_burst("abort", 100, -1, 0, 100);
        run_burst("post_rst", 80, -1, 5, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
